// File: rtl/melody_sequencer.sv
// Multi-song note sequencer: per-song note/duration memory, tempo prescaler, IDLE/LOAD/PLAY/DONE control.
// Optional macro MELODY_SEQUENCER_LOOP_EN: when defined, a finished song restarts from its first entry.
module melody_sequencer #(
  parameter int NOTE_W    = 8,
  parameter int DUR_W     = 4,
  parameter int SONG_CNT  = 4,
  parameter int DEPTH     = 32,
  parameter int TICK_BASE = 4,
  localparam int SW       = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1,
  localparam int AW       = $clog2(SONG_CNT * DEPTH),
  localparam int IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW       = $clog2(TICK_BASE * 8) + 1,
  localparam int EW       = NOTE_W + DUR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [SW-1:0]     song_sel,
  input  logic [2:0]        speed,
  input  logic [2:0]        transpose,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [EW-1:0]     wr_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              note_start,
  output logic              busy,
  output logic              song_done
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  localparam int NW1 = NOTE_W + 1;

  state_t              state_q, state_d;
  logic [SW-1:0]       song_q, song_d;
  logic [IW-1:0]       index_q, index_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                first_q, first_d;

  logic [EW-1:0]       mem [SONG_CNT * DEPTH];
  logic [EW-1:0]       rd_data_q;
  logic [AW-1:0]       rd_addr;
  logic [DUR_W-1:0]    rd_dur;
  logic [NOTE_W-1:0]   rd_note;
  logic [PW-1:0]       period;
  logic                tick;
  logic [NOTE_W:0]     sum;

  // The read address follows the next-state pointer so the entry is ready during LOAD.
  assign rd_addr = AW'(song_d) * AW'(DEPTH) + AW'(index_d);
  assign rd_dur  = rd_data_q[EW-1:NOTE_W];
  assign rd_note = rd_data_q[NOTE_W-1:0];

  // NOTE: memory arrays carry no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign period = PW'(TICK_BASE) * (PW'(8) - PW'(speed));
  assign tick   = (presc_q >= period - PW'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      song_q  <= '0;
      index_q <= '0;
      presc_q <= '0;
      rem_q   <= '0;
      note_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      index_q <= index_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      note_q  <= note_d;
      first_q <= first_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    index_d = index_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    note_d  = note_q;
    first_d = 1'b0;
    if (start) begin
      state_d = LOAD;
      song_d  = song_sel;
      index_d = '0;
      presc_d = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (rd_dur == '0) begin
            state_d = DONE;
          end else begin
            state_d = PLAY;
            rem_d   = rd_dur;
            note_d  = rd_note;
            first_d = 1'b1;
          end
        end
        PLAY: begin
          if (en) begin
            if (tick) begin
              presc_d = '0;
              if (rem_q == DUR_W'(1)) begin
                if (index_q == IW'(DEPTH - 1)) begin
                  state_d = DONE;
                end else begin
                  index_d = index_q + IW'(1);
                  state_d = LOAD;
                end
              end else begin
                rem_d = rem_q - DUR_W'(1);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        DONE: begin
`ifdef MELODY_SEQUENCER_LOOP_EN
          state_d = LOAD;
          index_d = '0;
`else
          state_d = IDLE;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sum = {1'b0, note_q} + NW1'(transpose);

  always_comb begin
    note_out   = '0;
    note_valid = 1'b0;
    note_start = 1'b0;
    busy       = 1'b0;
    song_done  = 1'b0;
    case (state_q)
      LOAD: busy = 1'b1;
      PLAY: begin
        busy       = 1'b1;
        note_out   = sum[NOTE_W] ? {NOTE_W{1'b1}} : sum[NOTE_W-1:0];
        note_valid = en;
        note_start = first_q;
      end
      // A start arriving in DONE takes over, so the end-of-song pulse is withheld.
      DONE: begin
        busy      = 1'b1;
        song_done = ~start;
      end
      default: ;
    endcase
  end

endmodule
